// File: rtl/leg_solver.sv
// Computes the other leg b = isqrt(c*c - a*a) with shift-add squarers and a restoring root.
// Optional LEG_ROUND_EN: round the result to nearest instead of floor.
module leg_solver #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] b_out,
  output logic         err
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_SQ = CW'(W - 1);
  localparam logic [CW-1:0] RT_END  = CW'(W);

  typedef enum logic [1:0] {IDLE, SQ, RT, DONE} state_t;

  state_t          state, state_n;
  logic [2*W-1:0]  c_mcand, a_mcand;
  logic [W-1:0]    c_mplr, a_mplr;
  logic [2*W-1:0]  csq, asq;
  logic [2*W-1:0]  csq_n, asq_n;
  logic [2*W-1:0]  rad;
  logic [2*W+1:0]  rem, rem_sh, rem_n, trial;
  logic [W-1:0]    root, root_n, result;
  logic [CW-1:0]   cnt;
  logic            flag;
  logic            ge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SQ;
      SQ:   if (cnt == LAST_SQ) state_n = RT;
      RT:   if (cnt == RT_END) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SQ) || (state == RT);
  assign done = (state == DONE);

  always_comb begin
    csq_n  = csq + (c_mplr[0] ? c_mcand : '0);
    asq_n  = asq + (a_mplr[0] ? a_mcand : '0);
    rem_sh = {rem[2*W-1:0], rad[2*W-1 -: 2]};
    trial  = {{W{1'b0}}, root, 2'b01};
    ge     = (rem_sh >= trial);
    rem_n  = ge ? (rem_sh - trial) : rem_sh;
    root_n = {root[W-2:0], ge};
`ifdef LEG_ROUND_EN
    // Final remainder x - r^2 exceeding r means sqrt(x) lies above r + 0.5.
    result = root + W'(rem > {{(W+2){1'b0}}, root});
`else
    result = root;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_mcand <= '0;
      a_mcand <= '0;
      c_mplr  <= '0;
      a_mplr  <= '0;
      csq     <= '0;
      asq     <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      flag    <= 1'b0;
      b_out   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            c_mcand <= {{W{1'b0}}, c_in};
            a_mcand <= {{W{1'b0}}, a_in};
            c_mplr  <= c_in;
            a_mplr  <= a_in;
            flag    <= (a_in > c_in);
            csq     <= '0;
            asq     <= '0;
          end
        end
        SQ: begin
          csq     <= csq_n;
          asq     <= asq_n;
          c_mcand <= c_mcand << 1;
          a_mcand <= a_mcand << 1;
          c_mplr  <= c_mplr >> 1;
          a_mplr  <= a_mplr >> 1;
          if (cnt == LAST_SQ) begin
            rad  <= flag ? '0 : (csq_n - asq_n);
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RT: begin
          if (cnt == RT_END) begin
            b_out <= flag ? '0 : result;
            err   <= flag;
          end else begin
            rem  <= rem_n;
            root <= root_n;
            rad  <= rad << 2;
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
